// File: rtl/bar_handshake_merge_if.sv
// bar_handshake_merge_if
//   Bundles the three ready/valid source channels and the merged output
//   channel of bar_handshake_merge.
//   Signals:
//     handshake_arr_K_valid/ready, src_K_in1/in2 (K = 0..2) : source channels
//     handshake_valid/ready, in1, in2, src_id                : merged channel
//   Modports:
//     master : environment side (drives sources and consumer ready)
//     slave  : merge block side
interface bar_handshake_merge_if #(
  parameter int unsigned WIDTH = 5
);
  logic             handshake_arr_0_valid;
  logic             handshake_arr_1_valid;
  logic             handshake_arr_2_valid;
  logic             handshake_arr_0_ready;
  logic             handshake_arr_1_ready;
  logic             handshake_arr_2_ready;
  logic [WIDTH-1:0] src_0_in1;
  logic [WIDTH-1:0] src_0_in2;
  logic [WIDTH-1:0] src_1_in1;
  logic [WIDTH-1:0] src_1_in2;
  logic [WIDTH-1:0] src_2_in1;
  logic [WIDTH-1:0] src_2_in2;
  logic             handshake_valid;
  logic             handshake_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       src_id;

  modport master (
    output handshake_arr_0_valid, handshake_arr_1_valid, handshake_arr_2_valid,
    output src_0_in1, src_0_in2, src_1_in1, src_1_in2, src_2_in1, src_2_in2,
    output handshake_ready,
    input  handshake_arr_0_ready, handshake_arr_1_ready, handshake_arr_2_ready,
    input  handshake_valid, in1, in2, src_id
  );

  modport slave (
    input  handshake_arr_0_valid, handshake_arr_1_valid, handshake_arr_2_valid,
    input  src_0_in1, src_0_in2, src_1_in1, src_1_in2, src_2_in1, src_2_in2,
    input  handshake_ready,
    output handshake_arr_0_ready, handshake_arr_1_ready, handshake_arr_2_ready,
    output handshake_valid, in1, in2, src_id
  );
endinterface

// File: rtl/bar_handshake_merge.sv
// bar_handshake_merge
//   Round-robin merge of three ready/valid sources into one channel through
//   a two-entry FIFO. One transfer per cycle; source readiness never depends
//   on the consumer's handshake_ready.
//   Ports:
//     CLK          : clock, rising edge
//     ASYNCRESETN  : asynchronous active-low reset
//     hs (slave)   : source channels in, merged channel out
module bar_handshake_merge #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned N     = 3
) (
  input logic                  CLK,
  input logic                  ASYNCRESETN,
  bar_handshake_merge_if.slave hs
);

  logic [N-1:0]     w_src_valid;
  logic [WIDTH-1:0] w_src_in1 [N];
  logic [WIDTH-1:0] w_src_in2 [N];

  logic [1:0]       r_mem_id  [2];
  logic [WIDTH-1:0] r_mem_in1 [2];
  logic [WIDTH-1:0] r_mem_in2 [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_count;
  logic [1:0]       r_ptr;

  logic             w_win_valid;
  logic [1:0]       w_win;
  logic [2:0]       w_idx;
  logic             w_push;
  logic             w_pop;
  logic             w_rd;

  assign w_src_valid  = {hs.handshake_arr_2_valid, hs.handshake_arr_1_valid,
                         hs.handshake_arr_0_valid};
  assign w_src_in1[0] = hs.src_0_in1;
  assign w_src_in1[1] = hs.src_1_in1;
  assign w_src_in1[2] = hs.src_2_in1;
  assign w_src_in2[0] = hs.src_0_in2;
  assign w_src_in2[1] = hs.src_1_in2;
  assign w_src_in2[2] = hs.src_2_in2;

  // First valid source scanning from r_ptr with wrap.
  always_comb begin
    w_win_valid = 1'b0;
    w_win       = '0;
    w_idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + 3'(k);
      if (w_idx >= 3'(N)) begin
        w_idx = w_idx - 3'(N);
      end
      if (!w_win_valid && w_src_valid[w_idx]) begin
        w_win_valid = 1'b1;
        w_win       = w_idx[1:0];
      end
    end
  end

  // Reset gates readiness so no source sees ready while held in reset.
  assign w_push = w_win_valid & (r_count != 2'd2) & ASYNCRESETN;
  assign w_pop  = (r_count != 2'd0) & hs.handshake_ready;

  assign hs.handshake_arr_0_ready = w_push & (w_win == 2'd0);
  assign hs.handshake_arr_1_ready = w_push & (w_win == 2'd1);
  assign hs.handshake_arr_2_ready = w_push & (w_win == 2'd2);

  // When empty, the slot behind the head is the one most recently popped,
  // so reading it keeps the idle outputs at the last popped contents.
  assign w_rd = (r_count == 2'd0) ? ~r_head : r_head;

  assign hs.handshake_valid = (r_count != 2'd0);
  assign hs.in1             = r_mem_in1[w_rd];
  assign hs.in2             = r_mem_in2[w_rd];
  assign hs.src_id          = r_mem_id[w_rd];

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= '0;
      r_ptr   <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_mem_id[i]  <= '0;
        r_mem_in1[i] <= '0;
        r_mem_in2[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_id[r_tail]  <= w_win;
        r_mem_in1[r_tail] <= w_src_in1[w_win];
        r_mem_in2[r_tail] <= w_src_in2[w_win];
        r_tail            <= ~r_tail;
        r_ptr             <= (w_win == 2'd2) ? 2'd0 : 2'(w_win + 2'd1);
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= 2'(r_count + 2'd1);
        2'b01:   r_count <= 2'(r_count - 2'd1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bar_handshake_merge.sv
// tb_bar_handshake_merge
//   Scoreboard bench for bar_handshake_merge. The driver applies per-cycle
//   stimulus, predicts grants from a round-robin queue model and pushes the
//   expected entries; a separate monitor compares the head against the
//   scoreboard on every falling edge and retires entries on pop.
module tb_bar_handshake_merge;

  typedef struct {
    int id;
    int a;
    int b;
  } ent_t;

  logic CLK;
  logic ASYNCRESETN;

  bar_handshake_merge_if #(.WIDTH(5)) hs ();

  bar_handshake_merge #(.WIDTH(5), .N(3)) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .hs         (hs)
  );

  int   total = 0;
  int   bad   = 0;
  ent_t q[$];
  int   log_ids[$];
  int   ptr = 0;
  int   p1[3];
  int   p2[3];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int readies();
    return {29'd0, hs.handshake_arr_2_ready, hs.handshake_arr_1_ready,
            hs.handshake_arr_0_ready};
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input logic [2:0] v, input logic hr, input bit rnd);
    int   win;
    int   exp_r;
    bit   pend;
    ent_t e;
    if (rnd) begin
      for (int k = 0; k < 3; k++) begin
        p1[k] = int'($urandom_range(0, 31));
        p2[k] = int'($urandom_range(0, 31));
      end
    end
    hs.handshake_arr_0_valid = v[0];
    hs.handshake_arr_1_valid = v[1];
    hs.handshake_arr_2_valid = v[2];
    hs.src_0_in1 = 5'(p1[0]); hs.src_0_in2 = 5'(p2[0]);
    hs.src_1_in1 = 5'(p1[1]); hs.src_1_in2 = 5'(p2[1]);
    hs.src_2_in1 = 5'(p1[2]); hs.src_2_in2 = 5'(p2[2]);
    hs.handshake_ready = hr;
    #1;
    win = -1;
    for (int i = 0; i < 3; i++) begin
      if (win < 0 && v[(ptr + i) % 3]) win = (ptr + i) % 3;
    end
    pend  = (win >= 0) && (q.size() < 2);
    exp_r = pend ? (1 << win) : 0;
    chk("src_ready", readies(), exp_r);
    if (pend) begin
      e.id = win;
      e.a  = p1[win];
      e.b  = p2[win];
    end
    @(posedge CLK);
    #1;
    if (pend) begin
      q.push_back(e);
      ptr = (win + 1) % 3;
    end
  endtask

  // Called just after a rising edge; asserts reset away from any edge.
  task automatic do_reset();
    #1;
    ASYNCRESETN = 1'b0;
    #1;
    chk("rst_valid", int'(hs.handshake_valid), 0);
    chk("rst_in1", int'(hs.in1), 0);
    chk("rst_in2", int'(hs.in2), 0);
    chk("rst_src_id", int'(hs.src_id), 0);
    chk("rst_ready", readies(), 0);
    q.delete();
    ptr = 0;
    @(posedge CLK);
    #1;
    ASYNCRESETN = 1'b1;
    #1;
    chk("post_rst_valid", int'(hs.handshake_valid), 0);
  endtask

  // Monitor: compare the head against the scoreboard mid-cycle.
  initial begin
    ent_t e;
    forever begin
      @(negedge CLK);
      if (ASYNCRESETN) begin
        chk("out_valid", int'(hs.handshake_valid), int'(q.size() != 0));
        if (q.size() != 0) begin
          e = q[0];
          chk("out_src_id", int'(hs.src_id), e.id);
          chk("out_in1", int'(hs.in1), e.a);
          chk("out_in2", int'(hs.in2), e.b);
          if (hs.handshake_ready) begin
            void'(q.pop_front());
            log_ids.push_back(e.id);
          end
        end
      end
    end
  end

  initial begin
    ASYNCRESETN = 1'b0;
    hs.handshake_arr_0_valid = 1'b1;
    hs.handshake_arr_1_valid = 1'b1;
    hs.handshake_arr_2_valid = 1'b1;
    hs.src_0_in1 = '0; hs.src_0_in2 = '0;
    hs.src_1_in1 = '0; hs.src_1_in2 = '0;
    hs.src_2_in1 = '0; hs.src_2_in2 = '0;
    hs.handshake_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      p1[k] = 0;
      p2[k] = 0;
    end
    #2;
    chk("init_valid", int'(hs.handshake_valid), 0);
    chk("init_ready", readies(), 0);
    @(posedge CLK);
    #1;
    ASYNCRESETN = 1'b1;

    // Single source 1 with fixed payload.
    p1[1] = 5'h0A;
    p2[1] = 5'h15;
    cycle(3'b010, 1'b1, 1'b0);
    chk("single_in1", int'(hs.in1), 5'h0A);
    chk("single_in2", int'(hs.in2), 5'h15);
    chk("single_id", int'(hs.src_id), 1);
    cycle(3'b000, 1'b1, 1'b0);
    cycle(3'b000, 1'b1, 1'b0);

    // Round robin from reset with distinct payloads.
    do_reset();
    log_ids.delete();
    for (int k = 0; k < 3; k++) begin
      p1[k] = k + 1;
      p2[k] = 20 + k;
    end
    for (int c = 0; c < 7; c++) cycle(3'b111, 1'b1, 1'b0);
    cycle(3'b000, 1'b1, 1'b0);
    cycle(3'b000, 1'b1, 1'b0);
    chk("rr_count", log_ids.size(), 7);
    for (int i = 0; i < log_ids.size(); i++) chk("rr_order", log_ids[i], i % 3);

    // Backpressure, valid withdrawal while full, then release.
    do_reset();
    for (int c = 0; c < 5; c++) cycle(3'b111, 1'b0, 1'b1);
    cycle(3'b100, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, 1'b1);
    log_ids.delete();
    for (int c = 0; c < 3; c++) cycle(3'b111, 1'b1, 1'b1);
    chk("bp_pops", log_ids.size(), 3);
    for (int i = 0; i < 3 && i < log_ids.size(); i++) chk("bp_order", log_ids[i], i);

    // Refill to two entries, then reset mid-cycle.
    cycle(3'b111, 1'b0, 1'b1);
    chk("full_valid", int'(hs.handshake_valid), 1);
    do_reset();

    // Random valid/ready traffic.
    for (int c = 0; c < 1000; c++) begin
      cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 1'b1);
    end

    for (int c = 0; c < 4; c++) cycle(3'b000, 1'b1, 1'b1);
    chk("drain_valid", int'(hs.handshake_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
